// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer.
// MORSE_PROSIGN_EN widens element storage to six for punctuation prosigns.
package morse_pkg;

`ifdef MORSE_PROSIGN_EN
    localparam int unsigned MAX_ELEMS = 6;
`else
    localparam int unsigned MAX_ELEMS = 5;
`endif
    localparam int unsigned LEN_W = $clog2(MAX_ELEMS + 1);
    localparam int unsigned PAT_W = MAX_ELEMS;

    localparam int unsigned DOT       = 1;
    localparam int unsigned DASH      = 3;
    localparam int unsigned EL_GAP    = 1;
    localparam int unsigned CHAR_GAP  = 3;
    localparam int unsigned ERR_UNITS = 1;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StElGap,
        StCharGap,
        StWordGap,
        StErr
    } state_e;

endpackage

// File: rtl/morse_rom.sv
// Combinational ASCII -> Morse lookup; pattern is left-aligned, 1 = dash.
// Space is supported with len 0. MORSE_PROSIGN_EN adds . , ? / =
module morse_rom
    import morse_pkg::*;
(
    input  logic [7:0]       char_data,
    output logic             supported,
    output logic [LEN_W-1:0] len,
    output logic [PAT_W-1:0] pattern
);

    logic [7:0] c;
    logic       hit;
    logic [2:0] l;
    logic [5:0] b;
    logic [5:0] left6;

    always_comb begin
        c = char_data;
        if (char_data >= 8'h61 && char_data <= 8'h7a) begin
            c = char_data - 8'h20;
        end
        hit = 1'b1;
        l   = 3'd0;
        b   = 6'b000000;
        // b holds the l elements right-aligned, first element at bit l-1
        case (c)
            8'h20: begin l = 3'd0; b = 6'b000000; end
            8'h41: begin l = 3'd2; b = 6'b000001; end
            8'h42: begin l = 3'd4; b = 6'b001000; end
            8'h43: begin l = 3'd4; b = 6'b001010; end
            8'h44: begin l = 3'd3; b = 6'b000100; end
            8'h45: begin l = 3'd1; b = 6'b000000; end
            8'h46: begin l = 3'd4; b = 6'b000010; end
            8'h47: begin l = 3'd3; b = 6'b000110; end
            8'h48: begin l = 3'd4; b = 6'b000000; end
            8'h49: begin l = 3'd2; b = 6'b000000; end
            8'h4a: begin l = 3'd4; b = 6'b000111; end
            8'h4b: begin l = 3'd3; b = 6'b000101; end
            8'h4c: begin l = 3'd4; b = 6'b000100; end
            8'h4d: begin l = 3'd2; b = 6'b000011; end
            8'h4e: begin l = 3'd2; b = 6'b000010; end
            8'h4f: begin l = 3'd3; b = 6'b000111; end
            8'h50: begin l = 3'd4; b = 6'b000110; end
            8'h51: begin l = 3'd4; b = 6'b001101; end
            8'h52: begin l = 3'd3; b = 6'b000010; end
            8'h53: begin l = 3'd3; b = 6'b000000; end
            8'h54: begin l = 3'd1; b = 6'b000001; end
            8'h55: begin l = 3'd3; b = 6'b000001; end
            8'h56: begin l = 3'd4; b = 6'b000001; end
            8'h57: begin l = 3'd3; b = 6'b000011; end
            8'h58: begin l = 3'd4; b = 6'b001001; end
            8'h59: begin l = 3'd4; b = 6'b001011; end
            8'h5a: begin l = 3'd4; b = 6'b001100; end
            8'h30: begin l = 3'd5; b = 6'b011111; end
            8'h31: begin l = 3'd5; b = 6'b001111; end
            8'h32: begin l = 3'd5; b = 6'b000111; end
            8'h33: begin l = 3'd5; b = 6'b000011; end
            8'h34: begin l = 3'd5; b = 6'b000001; end
            8'h35: begin l = 3'd5; b = 6'b000000; end
            8'h36: begin l = 3'd5; b = 6'b010000; end
            8'h37: begin l = 3'd5; b = 6'b011000; end
            8'h38: begin l = 3'd5; b = 6'b011100; end
            8'h39: begin l = 3'd5; b = 6'b011110; end
`ifdef MORSE_PROSIGN_EN
            8'h2e: begin l = 3'd6; b = 6'b010101; end
            8'h2c: begin l = 3'd6; b = 6'b110011; end
            8'h3f: begin l = 3'd6; b = 6'b001100; end
            8'h2f: begin l = 3'd5; b = 6'b010010; end
            8'h3d: begin l = 3'd5; b = 6'b010001; end
`endif
            default: hit = 1'b0;
        endcase
        left6     = b << (3'd6 - l);
        supported = hit;
        len       = LEN_W'(l);
        pattern   = left6[5 -: PAT_W];
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts ASCII over valid/ready, times marks and gaps in units.
// Build with MORSE_PROSIGN_EN to key punctuation prosigns instead of flagging them.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES    = 4800000,
    parameter bit          LED_ACTIVE_LOW = 1'b0,
    parameter int unsigned WORD_GAP_UNITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key,
    output logic       busy,
    output logic       err,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b
);

    localparam int unsigned MAX_UNITS = (WORD_GAP_UNITS > DASH) ? WORD_GAP_UNITS : DASH;
    localparam int unsigned CNT_W     = $clog2(MAX_UNITS * UNIT_CYCLES);

    function automatic logic [CNT_W-1:0] load(input int unsigned units);
        return CNT_W'(units * UNIT_CYCLES - 32'd1);
    endfunction

    logic             rom_supported;
    logic [LEN_W-1:0] rom_len;
    logic [PAT_W-1:0] rom_pattern;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] left_q, left_d;
    logic             err_d, mark_d, dash_d;
    logic             key_q, err_q, led_r_q, led_g_q, led_b_q;

    morse_rom u_rom (
        .char_data (char_data),
        .supported (rom_supported),
        .len       (rom_len),
        .pattern   (rom_pattern)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        pat_d   = pat_q;
        left_d  = left_q;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (char_valid) begin
                    if (!rom_supported) begin
                        state_d = StErr;
                        cnt_d   = load(ERR_UNITS);
                        err_d   = 1'b1;
                    end else if (rom_len == '0) begin
                        state_d = StWordGap;
                        cnt_d   = load(WORD_GAP_UNITS);
                    end else begin
                        state_d = StMark;
                        pat_d   = rom_pattern;
                        left_d  = rom_len;
                        cnt_d   = load(rom_pattern[PAT_W-1] ? DASH : DOT);
                    end
                end
            end
            StMark: begin
                if (cnt_q == '0) begin
                    if (left_q > LEN_W'(1)) begin
                        state_d = StElGap;
                        cnt_d   = load(EL_GAP);
                        pat_d   = pat_q << 1;
                        left_d  = left_q - LEN_W'(1);
                    end else begin
                        state_d = StCharGap;
                        cnt_d   = load(CHAR_GAP);
                    end
                end
            end
            StElGap: begin
                if (cnt_q == '0) begin
                    state_d = StMark;
                    cnt_d   = load(pat_q[PAT_W-1] ? DASH : DOT);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end
            end
        endcase
        // Outputs are registered from next state so they line up with the state register
        mark_d = (state_d == StMark);
        dash_d = pat_d[PAT_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pat_q   <= '0;
            left_q  <= '0;
            key_q   <= 1'b0;
            err_q   <= 1'b0;
            led_r_q <= LED_ACTIVE_LOW;
            led_g_q <= LED_ACTIVE_LOW;
            led_b_q <= LED_ACTIVE_LOW;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            left_q  <= left_d;
            key_q   <= mark_d;
            err_q   <= err_d;
            led_r_q <= (state_d == StErr) ^ LED_ACTIVE_LOW;
            led_g_q <= (mark_d & ~dash_d) ^ LED_ACTIVE_LOW;
            led_b_q <= (mark_d & dash_d) ^ LED_ACTIVE_LOW;
        end
    end

    assign char_ready = (state_q == StIdle) && !rst;
    assign busy       = (state_q != StIdle);
    assign key        = key_q;
    assign err        = err_q;
    assign led_r      = led_r_q;
    assign led_g      = led_g_q;
    assign led_b      = led_b_q;

endmodule
